// File: rtl/lc3_pkg.sv
// Shared LC-3 fetch types: fetch FSM states, PC mux selects and the datapath width.
package lc3_pkg;

  localparam int WORD_W = 16;

  localparam logic [1:0] SEL_PC_INC = 2'b00;
  localparam logic [1:0] SEL_PC_EAB = 2'b01;
  localparam logic [1:0] SEL_PC_BUS = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    MEM_WAIT,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory read channel plus the ir valid/ready channel to decode.
interface instr_fetch_if;
  import lc3_pkg::*;

  logic [WORD_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_ready;
  logic [WORD_W-1:0] mem_rdata;
  logic [WORD_W-1:0] ir;
  logic [WORD_W-1:0] fetch_pc;
  logic              ir_valid;
  logic              ir_ready;

  // master is the fetch unit; slave is the memory + decode side.
  modport master (
    output mem_addr, mem_req, ir, fetch_pc, ir_valid,
    input  mem_ready, mem_rdata, ir_ready
  );

  modport slave (
    input  mem_addr, mem_req, ir, fetch_pc, ir_valid,
    output mem_ready, mem_rdata, ir_ready
  );

endinterface

// File: rtl/ifetch_watchdog.sv
// Memory-wait watchdog: counts MEM_WAIT cycles without mem_ready and raises a sticky fetch_err.
module ifetch_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start,      // entering MEM_WAIT next cycle
  input  logic active,     // currently in MEM_WAIT
  input  logic mem_ready,
  output logic expire,     // this cycle is the last allowed wait cycle
  output logic fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  assign expire = active && !mem_ready && (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (start) begin
        cnt <= '0;
      end else if (active && !mem_ready) begin
        cnt <= cnt + 1'b1;
      end
      if (expire) begin
        fetch_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// LC-3 fetch sequencer: PC -> MAR, ldPC pulse, req/ready memory read, ir valid/ready to decode.
// Optional memory-wait timeout with sticky fetch_err is built when IFETCH_TIMEOUT_EN is defined.
module instr_fetch
  import lc3_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic [WORD_W-1:0] pc_in,
  output logic              ld_pc,
  output logic [1:0]        sel_pc,
  output logic              fetch_err,
  instr_fetch_if.master     bus
);

  fetch_state_t      state, state_d;
  logic [WORD_W-1:0] mar;
  logic [WORD_W-1:0] ir_q;
  logic [WORD_W-1:0] fetch_pc_q;
  logic              ir_valid_q;
  logic              drop;
  logic              mem_req_c;
  logic              timeout;

  assign sel_pc       = SEL_PC_INC;
  assign bus.mem_addr = mar;
  assign bus.mem_req  = mem_req_c;
  assign bus.ir       = ir_q;
  assign bus.fetch_pc = fetch_pc_q;
  assign bus.ir_valid = ir_valid_q;

`ifdef IFETCH_TIMEOUT_EN
  ifetch_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .start     (state == ADDR && !flush),
    .active    (state == MEM_WAIT),
    .mem_ready (bus.mem_ready),
    .expire    (timeout),
    .fetch_err (fetch_err)
  );
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      // NOTE: registers take <= so every flop samples pre-edge values, independent of block order.
      state <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise unassigned paths infer latches.
    state_d   = state;
    ld_pc     = 1'b0;
    mem_req_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && !flush && !fetch_err) state_d = ADDR;
      end
      ADDR: begin
        ld_pc   = !flush;
        state_d = flush ? IDLE : MEM_WAIT;
      end
      MEM_WAIT: begin
        // The read is never abandoned on flush; its data is discarded when it lands.
        mem_req_c = 1'b1;
        if (bus.mem_ready) begin
          state_d = (drop || flush) ? IDLE : HOLD;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (flush) begin
          state_d = IDLE;
        end else if (bus.ir_ready) begin
          state_d = enable ? ADDR : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mar        <= '0;
      ir_q       <= '0;
      fetch_pc_q <= '0;
      ir_valid_q <= 1'b0;
      drop       <= 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (!flush) mar <= pc_in;
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            if (!(drop || flush)) begin
              ir_q       <= bus.mem_rdata;
              fetch_pc_q <= mar;
              ir_valid_q <= 1'b1;
            end
            drop <= 1'b0;
          end else if (timeout) begin
            drop <= 1'b0;
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        HOLD: begin
          // flush outranks ir_ready; either way the word leaves HOLD.
          if (flush || bus.ir_ready) ir_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  a_ld_req_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(ld_pc && bus.mem_req));

  a_addr_stable: assert property (@(posedge clk) disable iff (reset)
    (bus.mem_req && !bus.mem_ready && !timeout) |=> (bus.mem_req && $stable(bus.mem_addr)));

  a_ir_stable: assert property (@(posedge clk) disable iff (reset)
    (bus.ir_valid && !bus.ir_ready && !flush) |=> (bus.ir_valid && $stable(bus.ir)));

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed fetch scenarios plus randomized traffic checked
// every cycle against a transaction-level reference model.
module tb_instr_fetch;
  import lc3_pkg::*;

`ifdef IFETCH_TIMEOUT_EN
  localparam bit TO_EN  = 1'b1;
  localparam int TO_CYC = 8;
`else
  localparam bit TO_EN  = 1'b0;
  localparam int TO_CYC = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        flush;
  logic [15:0] pc_in;
  logic        ld_pc;
  logic [1:0]  sel_pc;
  logic        fetch_err;

  instr_fetch_if bus ();

  instr_fetch #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .flush     (flush),
    .pc_in     (pc_in),
    .ld_pc     (ld_pc),
    .sel_pc    (sel_pc),
    .fetch_err (fetch_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents seen by the fetch unit.
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    if (a == 16'h3000) return 16'h1234;
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // ---------------- memory responder and PC register (driven from the main thread) -----------
  bit          rand_lat = 1'b0;
  int          req_lat  = 0;
  bit          in_req   = 1'b0;
  int          lat_left = 0;
  bit          ovr_en   = 1'b0;
  logic [15:0] ovr_data = 16'h0;

  task automatic respond();
    if (!reset && bus.mem_req) begin
      if (!in_req) begin
        in_req   = 1'b1;
        lat_left = rand_lat ? int'($urandom_range(0, 4)) : req_lat;
      end
      bus.mem_ready = (lat_left == 0);
      bus.mem_rdata = bus.mem_ready ? (ovr_en ? ovr_data : mem_fn(bus.mem_addr)) : 16'($urandom);
      if (lat_left > 0) lat_left--;
    end else begin
      in_req        = 1'b0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 16'($urandom);
    end
  endtask

  // Advance one clock; the PC increments on every ldPC strobe the DUT issues.
  task automatic tick();
    logic ld_prev;
    @(negedge clk);
    ld_prev = ld_pc;
    @(posedge clk);
    #1;
    if (ld_prev && !reset) pc_in = pc_in + 16'd1;
    respond();
  endtask

  // ---------------- reference model, compared every cycle ----------------
  typedef enum {M_IDLE, M_LAUNCH, M_READ, M_HOLD} mphase_t;
  mphase_t     mph    = M_IDLE;
  logic [15:0] m_mar  = '0;
  logic [15:0] m_ir   = '0;
  logic [15:0] m_fpc  = '0;
  bit          m_valid = 1'b0;
  bit          m_drop  = 1'b0;
  bit          m_err   = 1'b0;
  int          m_wcnt  = 0;

  always @(negedge clk) begin
    if (reset) begin
      check("rst_ld_pc",    ld_pc,        0);
      check("rst_mem_req",  bus.mem_req,  0);
      check("rst_ir_valid", bus.ir_valid, 0);
      check("rst_ir",       bus.ir,       0);
      check("rst_fetch_pc", bus.fetch_pc, 0);
      check("rst_fetch_err", fetch_err,   0);
      mph = M_IDLE; m_mar = '0; m_ir = '0; m_fpc = '0;
      m_valid = 0; m_drop = 0; m_err = 0; m_wcnt = 0;
    end else begin
      check("cyc_ld_pc",     ld_pc,        (mph == M_LAUNCH) && !flush);
      check("cyc_mem_req",   bus.mem_req,  mph == M_READ);
      check("cyc_mem_addr",  bus.mem_addr, m_mar);
      check("cyc_ir_valid",  bus.ir_valid, m_valid);
      check("cyc_ir",        bus.ir,       m_ir);
      check("cyc_fetch_pc",  bus.fetch_pc, m_fpc);
      check("cyc_sel_pc",    sel_pc,       SEL_PC_INC);
      check("cyc_fetch_err", fetch_err,    m_err);
      case (mph)
        M_IDLE:   if (enable && !flush && !m_err) mph = M_LAUNCH;
        M_LAUNCH: if (flush) mph = M_IDLE;
                  else begin m_mar = pc_in; m_wcnt = 0; mph = M_READ; end
        M_READ: begin
          if (bus.mem_ready) begin
            if (!(m_drop || flush)) begin
              m_ir = bus.mem_rdata; m_fpc = m_mar; m_valid = 1; mph = M_HOLD;
            end else begin
              mph = M_IDLE;
            end
            m_drop = 0;
          end else begin
            m_wcnt++;
            if (TO_EN && m_wcnt == TO_CYC) begin
              m_err = 1; m_drop = 0; mph = M_IDLE;
            end else if (flush) begin
              m_drop = 1;
            end
          end
        end
        M_HOLD: begin
          if (flush) begin
            m_valid = 0; mph = M_IDLE;
          end else if (bus.ir_ready) begin
            m_valid = 0; mph = enable ? M_LAUNCH : M_IDLE;
          end
        end
        default: mph = M_IDLE;
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: simulation did not finish, got running, expected done");
    $fatal(1, "simulation time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    int ld_cnt, req_cnt, bad, guard;
    bit beef_seen;
    reset = 1'b1; enable = 1'b0; flush = 1'b0; pc_in = 16'h0;
    bus.ir_ready = 1'b0; bus.mem_ready = 1'b0; bus.mem_rdata = 16'h0;
    tick(); tick();
    check("init_mem_req", bus.mem_req, 0);
    check("init_ir_valid", bus.ir_valid, 0);
    reset = 1'b0;

    // 1: zero-wait fetch from 3000
    pc_in = 16'h3000; enable = 1'b1; req_lat = 0;
    tick();
    check("t1_ld_pc_c1", ld_pc, 1);
    check("t1_no_req_c1", bus.mem_req, 0);
    tick();
    check("t1_mem_req_c2", bus.mem_req, 1);
    check("t1_mem_addr_c2", bus.mem_addr, 16'h3000);
    check("t1_ld_pc_c2", ld_pc, 0);
    tick();
    check("t1_ir_valid_c3", bus.ir_valid, 1);
    check("t1_ir_c3", bus.ir, 16'h1234);
    check("t1_fetch_pc_c3", bus.fetch_pc, 16'h3000);

    // 3: consumer stalls for 10 cycles
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.ir !== 16'h1234 || ld_pc !== 1'b0 || bus.mem_req !== 1'b0 || bus.ir_valid !== 1'b1)
        bad++;
    end
    check("t3_hold_stable", bad, 0);
    req_lat = 4; bus.ir_ready = 1'b1;
    tick();
    check("t3_next_ld_pc", ld_pc, 1);
    check("t3_ir_consumed", bus.ir_valid, 0);
    bus.ir_ready = 1'b0;

    // 2: four wait states on the read of 3001
    ld_cnt = 1; req_cnt = 0; bad = 0; guard = 0;
    while (!bus.ir_valid && guard < 20) begin
      tick(); guard++;
      ld_cnt += int'(ld_pc);
      if (bus.mem_req) begin
        req_cnt++;
        if (bus.mem_addr !== 16'h3001) bad++;
      end
    end
    check("t2_delivered", bus.ir_valid, 1);
    check("t2_req_cycles", req_cnt, 5);
    check("t2_one_ld_pc", ld_cnt, 1);
    check("t2_addr_stable", bad, 0);
    check("t2_fetch_pc", bus.fetch_pc, 16'h3001);
    check("t2_ir", bus.ir, mem_fn(16'h3001));

    // 4: flush during MEM_WAIT discards the returning BEEF
    req_lat = 3; bus.ir_ready = 1'b1;
    tick();
    bus.ir_ready = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; enable = 1'b0; ovr_en = 1'b1; ovr_data = 16'hBEEF;
    beef_seen = 1'b0; guard = 0;
    while (bus.mem_req && guard < 10) begin
      if (bus.mem_ready && bus.mem_rdata == 16'hBEEF) beef_seen = 1'b1;
      tick(); guard++;
    end
    ovr_en = 1'b0;
    check("t4_beef_returned", beef_seen, 1);
    check("t4_req_done", bus.mem_req, 0);
    check("t4_ir_valid", bus.ir_valid, 0);
    check("t4_ir_kept", bus.ir, mem_fn(16'h3001));
    tick();
    check("t4_idle_no_ld", ld_pc, 0);

    // 5: asynchronous reset in the middle of a read
    enable = 1'b1; req_lat = 1000;
    tick(); tick(); tick();
    check("t5_in_wait", bus.mem_req, 1);
    reset = 1'b1;
    #1;
    check("t5_req_dropped", bus.mem_req, 0);
    check("t5_ir_valid", bus.ir_valid, 0);
    check("t5_ir_cleared", bus.ir, 0);
    check("t5_fetch_pc_cleared", bus.fetch_pc, 0);
    tick();
    reset = 1'b0; enable = 1'b0;
    tick();

`ifdef IFETCH_TIMEOUT_EN
    // 6: memory never answers
    pc_in = 16'h4000; enable = 1'b1; req_lat = 1000;
    ld_cnt = 0; req_cnt = 0; guard = 0;
    while (!fetch_err && guard < 30) begin
      tick(); guard++;
      ld_cnt  += int'(ld_pc);
      req_cnt += int'(bus.mem_req);
    end
    check("t6_fetch_err", fetch_err, 1);
    check("t6_req_cycles", req_cnt, TO_CYC);
    check("t6_req_dropped", bus.mem_req, 0);
    check("t6_one_ld_pc", ld_cnt, 1);
    ld_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      ld_cnt += int'(ld_pc);
    end
    check("t6_no_more_ld_pc", ld_cnt, 0);
    reset = 1'b1; tick(); reset = 1'b0; enable = 1'b0;
`endif

    // randomized traffic
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      enable       = ($urandom_range(0, 9) < 8);
      flush        = ($urandom_range(0, 19) == 0);
      bus.ir_ready = ($urandom_range(0, 9) < 6);
      if (flush && $urandom_range(0, 1) == 1) pc_in = 16'($urandom);
      reset        = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0; flush = 1'b0; enable = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
